cell_program_sequencer: RTL and testbench
=========================================

# cell_program_sequencer

Instruction sequencer for the cellular-automaton array: fetches the per-generation program from instruction memory and broadcasts `instruction`, `program_counter` and `execution_enable` to every cell core in lock-step. At the end of each generation it pulses a commit strobe so the array latches `nextState`. It can also optionally wait for a frame sync before starting the next generation. It sits between the host/control registers and the cell array, and is the driving end of the cell-core instruction interface.

## Interface
- `PC_WIDTH`, 12, program counter / instruction-memory address width
- `INSTR_WIDTH`, 16, instruction word width
- `GEN_WIDTH`, 16, generation counter width
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-low
- `run`  in  1  level; high = keep executing generations
- `prog_len`  in  PC_WIDTH  number of instructions per generation, sampled at generation start
- `imem_addr`  out  PC_WIDTH  instruction-memory read address
- `imem_rdata`  in  INSTR_WIDTH  read data, valid exactly 1 cycle after `imem_addr`
- `frame_sync`  in  1  single-cycle pulse from video timing (used only with `SEQ_FRAME_SYNC_EN`)
- `instruction`  out  INSTR_WIDTH  broadcast instruction, registered
- `program_counter`  out  PC_WIDTH  address of `instruction`, registered
- `execution_enable`  out  1  high when `instruction`/`program_counter` are valid, registered
- `state_commit`  out  1  one-cycle pulse; the array latches `nextState`
- `busy`  out  1  high in any state other than IDLE
- `generation`  out  GEN_WIDTH  completed-generation count, wraps modulo 2^GEN_WIDTH

## Operation
- FSM states: IDLE, FETCH, COMMIT, WAIT_SYNC.
- IDLE: `imem_addr`=0, `busy`=0. If `run`=1, latch `prog_len` into `len_q`.
  - If `len_q`≠0, go to FETCH with fetch pointer `fp`=0.
  - If `len_q`=0, go straight to COMMIT.
- FETCH:
  - Drive `imem_addr`=`fp` and increment `fp` each cycle while `fp`<`len_q`.
  - A delayed-valid flop `v` plus delayed address `fp_d` track the read.
  - When `v`=1, register `instruction`←`imem_rdata`, `program_counter`←`fp_d`, `execution_enable`←1.
  - After the last read returns (address `len_q`−1), go to COMMIT.
- COMMIT: one cycle. `state_commit`=1, `execution_enable`=0, `generation`+1.
  - With `SEQ_FRAME_SYNC_EN` defined, go to WAIT_SYNC.
  - Without it: if `run`=1, re-latch `prog_len` and start the next generation; else go to IDLE.
- WAIT_SYNC: hold outputs idle. Either exit takes priority over waiting:
  - `run`=0 → IDLE.
  - `frame_sync`=1 → start the next generation.
- `run` falling mid-generation does not abort. The current generation completes, including COMMIT, then the FSM returns to IDLE.
- `prog_len` changes mid-generation are ignored until the next latch.
- `fp` never exceeds `len_q`. When `prog_len`=2^PC_WIDTH−1, the address must not wrap.

## Timing
- Reset (async assert, sync deassert in the surrounding reset tree) sets:
  - state=IDLE
  - `instruction`=0, `program_counter`=0, `execution_enable`=0
  - `state_commit`=0, `busy`=0, `generation`=0, `imem_addr`=0
- Let `run` be sampled high at edge E0. Then:
  - `imem_addr`=0 during cycle E0→E1.
  - First `execution_enable`=1, `program_counter`=0, is in cycle E2→E3.
- Throughput: one instruction per cycle, with no bubbles inside a generation.
- For length N≥1:
  - `execution_enable` is high for exactly N consecutive cycles with `program_counter` 0..N−1.
  - `state_commit` is high in the cycle immediately after the last enabled cycle.
- Back-to-back generations (no sync): the next generation's `program_counter`=0 appears 2 cycles after the `state_commit` cycle.
- Reset asserted mid-generation: all outputs clear immediately, and no `state_commit` is issued.

## Configuration
- `SEQ_FRAME_SYNC_EN` defined:
  - The WAIT_SYNC state and the `frame_sync` input are used.
  - Each generation after the first waits for a `frame_sync` pulse; the first generation starts from IDLE without one.
- `SEQ_FRAME_SYNC_EN` not defined:
  - WAIT_SYNC is absent and `frame_sync` is ignored (port kept, unused).
  - Generations run back-to-back while `run`=1.

## Structure
- Shared package `seq_pkg`: the FSM state enum `seq_state_t` and default width constants.
- The ISA opcode/register defines stay in the existing ISA include; the sequencer does not decode opcodes.
- One sub-module, `seq_fetch_pipe`: the fetch pointer, the 1-cycle read-latency alignment (`v`, `fp_d`) and the output registers. The FSM lives in the top level.

## Test plan
- `prog_len`=3, memory {A000,B001,C002}, `run` pulsed 1 cycle:
  - `execution_enable` high 3 cycles, starting 2 cycles after `run`, with PC 0,1,2 and matching instructions.
  - `state_commit` in the next cycle, `generation`=1, then IDLE.
- `prog_len`=0, `run`=1 for one cycle → `state_commit` one cycle later, `execution_enable` never high, `generation`=1.
- `run` held high, `prog_len`=2, no macro → generations repeat with a 2-cycle gap (commit + 1 fetch cycle) between PC=1 and the next PC=0; `generation` counts 1,2,3.
- With `SEQ_FRAME_SYNC_EN`, `run`=1:
  - After the first commit, no execution until `frame_sync`.
  - `frame_sync` at cycle T → PC=0 valid at T+2.
- `run` dropped while PC=1 of 4 → PC 2,3 still issued, commit issued, then IDLE.
- `rst` asserted during PC=2 → outputs zero asynchronously; after release, state is IDLE and `generation`=0.

Source files
------------

// File: rtl/cell_program_sequencer_pkg.sv
// Shared types for the cell program sequencer: FSM state encoding and default widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_pkg;

    localparam int PC_WIDTH_DEF    = 12;
    localparam int INSTR_WIDTH_DEF = 16;
    localparam int GEN_WIDTH_DEF   = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FETCH     = 2'd1,
        COMMIT    = 2'd2,
        WAIT_SYNC = 2'd3
    } seq_state_t;

endpackage

// File: rtl/cell_program_sequencer_fetch_pipe.sv
// Fetch pointer, 1-cycle instruction-memory read alignment and broadcast output registers.
// Latency: address to registered instruction is 2 cycles; one instruction per cycle.
// Backpressure: none; the cell array consumes every enabled cycle.
// Ports: fetching/start_slow/start_fast/len_q from the FSM, imem_addr/imem_rdata to
// instruction memory, instruction/program_counter/execution_enable to the array.
module seq_fetch_pipe #(
    parameter int PC_WIDTH    = 12,
    parameter int INSTR_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fetching,
    input  logic                   start_slow,
    input  logic                   start_fast,
    input  logic [PC_WIDTH-1:0]    len_q,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [PC_WIDTH-1:0]    imem_addr,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [PC_WIDTH-1:0]    program_counter,
    output logic                   execution_enable
);

    logic [PC_WIDTH-1:0] fp;
    logic [PC_WIDTH-1:0] fp_d;
    logic                v;
    logic                issue;

    // fp stops at len_q, so a full-range program never wraps the address.
    assign issue     = fetching && (fp < len_q);
    // Address 0 is presented whenever no read is issued, so a generation that
    // starts straight out of COMMIT/WAIT_SYNC already has word 0 on imem_rdata.
    assign imem_addr = issue ? fp : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fp               <= '0;
            fp_d             <= '0;
            v                <= 1'b0;
            instruction      <= '0;
            program_counter  <= '0;
            execution_enable <= 1'b0;
        end else begin
            if (start_slow) begin
                fp <= '0;
                v  <= 1'b0;
            end else if (start_fast) begin
                // Word 0 was read during the previous cycle; continue from 1.
                fp   <= PC_WIDTH'(1);
                fp_d <= '0;
                v    <= 1'b1;
            end else begin
                v    <= issue;
                fp_d <= fp;
                if (issue) begin
                    fp <= fp + 1'b1;
                end
            end

            if (v) begin
                instruction      <= imem_rdata;
                program_counter  <= fp_d;
                execution_enable <= 1'b1;
            end else begin
                execution_enable <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cell_program_sequencer.sv
// Lock-step instruction sequencer for the cell array; commits nextState once per generation.
// Latency: run sampled -> first enabled instruction 2 cycles later; back-to-back generations
// restart 2 cycles after the commit cycle. Backpressure: none.
// Optional feature macro SEQ_FRAME_SYNC_EN: after each commit wait for frame_sync before
// the next generation. Ports: run/prog_len control, imem_* memory read, instruction /
// program_counter / execution_enable / state_commit broadcast, busy and generation status.
module cell_program_sequencer
    import seq_pkg::*;
#(
    parameter int PC_WIDTH    = PC_WIDTH_DEF,
    parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter int GEN_WIDTH   = GEN_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic [PC_WIDTH-1:0]    prog_len,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   frame_sync,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [PC_WIDTH-1:0]    program_counter,
    output logic                   execution_enable,
    output logic                   state_commit,
    output logic                   busy,
    output logic [GEN_WIDTH-1:0]   generation
);

    seq_state_t          state;
    logic [PC_WIDTH-1:0] len_q;
    logic                start_req;
    logic                fast_start;
    logic                len_nz;
    logic                start_slow;
    logic                start_fast;

`ifndef SEQ_FRAME_SYNC_EN
    logic frame_sync_unused;
    assign frame_sync_unused = frame_sync;
`endif

    assign len_nz = (prog_len != '0);
    assign busy   = (state != IDLE);

    // A new generation begins at this edge; fast starts come from states that
    // were already holding address 0 on the memory.
    always_comb begin
        start_req  = 1'b0;
        fast_start = 1'b0;
        case (state)
            IDLE: start_req = run;
`ifdef SEQ_FRAME_SYNC_EN
            WAIT_SYNC: begin
                start_req  = run && frame_sync;
                fast_start = 1'b1;
            end
`else
            COMMIT: begin
                start_req  = run;
                fast_start = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign start_slow = start_req && !fast_start && len_nz;
    assign start_fast = start_req && fast_start && len_nz;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            len_q        <= '0;
            state_commit <= 1'b0;
            generation   <= '0;
        end else begin
            state_commit <= 1'b0;
            if (start_req) begin
                len_q <= prog_len;
                if (len_nz) begin
                    state <= FETCH;
                end else begin
                    // Empty program: the generation is just a commit.
                    state        <= COMMIT;
                    state_commit <= 1'b1;
                    generation   <= generation + 1'b1;
                end
            end else begin
                case (state)
                    IDLE: ;
                    FETCH: begin
                        // Commit follows the cycle that broadcasts the last word.
                        if (execution_enable && (program_counter == len_q - 1'b1)) begin
                            state        <= COMMIT;
                            state_commit <= 1'b1;
                            generation   <= generation + 1'b1;
                        end
                    end
`ifdef SEQ_FRAME_SYNC_EN
                    COMMIT: state <= WAIT_SYNC;
                    WAIT_SYNC: begin
                        if (!run) begin
                            state <= IDLE;
                        end
                    end
`else
                    COMMIT: state <= IDLE;
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

    seq_fetch_pipe #(
        .PC_WIDTH    (PC_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_fetch_pipe (
        .clk              (clk),
        .rst              (rst),
        .fetching         (state == FETCH),
        .start_slow       (start_slow),
        .start_fast       (start_fast),
        .len_q            (len_q),
        .imem_rdata       (imem_rdata),
        .imem_addr        (imem_addr),
        .instruction      (instruction),
        .program_counter  (program_counter),
        .execution_enable (execution_enable)
    );

endmodule

// File: tb/tb_cell_program_sequencer.sv
// Scoreboard bench for cell_program_sequencer: stimulus pushes expected broadcast and
// commit events with their cycle stamps; a negedge monitor pops and compares.
// Works in both builds; the frame-sync scenarios are compiled with SEQ_FRAME_SYNC_EN.
module tb_cell_program_sequencer;

    localparam int PCW = 12;
    localparam int IW  = 16;
    localparam int GW  = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           run = 1'b0;
    logic           frame_sync = 1'b0;
    logic [PCW-1:0] prog_len = '0;
    logic [PCW-1:0] imem_addr;
    logic [IW-1:0]  imem_rdata = '0;
    logic [IW-1:0]  instruction;
    logic [PCW-1:0] program_counter;
    logic           execution_enable;
    logic           state_commit;
    logic           busy;
    logic [GW-1:0]  generation;

    logic [IW-1:0]  mem [0:(1<<PCW)-1];

    cell_program_sequencer #(.PC_WIDTH(PCW), .INSTR_WIDTH(IW), .GEN_WIDTH(GW)) dut (
        .clk              (clk),
        .rst              (rst),
        .run              (run),
        .prog_len         (prog_len),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .frame_sync       (frame_sync),
        .instruction      (instruction),
        .program_counter  (program_counter),
        .execution_enable (execution_enable),
        .state_commit     (state_commit),
        .busy             (busy),
        .generation       (generation)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory: data for an address appears one cycle later.
    always @(posedge clk) imem_rdata <= mem[imem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_commit;
        int          at;
        int          pc;
        logic [IW-1:0] ins;
        int          gen;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  model_gen = 0;
    int  tests = 0;
    int  fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: a generation of n words broadcasts pc 0..n-1 on consecutive
    // cycles from t0, then commits on the following cycle.
    function automatic void push_gen(input int t0, input int n);
        ev_t e;
        for (int i = 0; i < n; i++) begin
            e.is_commit = 1'b0;
            e.at        = t0 + i;
            e.pc        = i;
            e.ins       = mem[i];
            e.gen       = 0;
            exp_q.push_back(e);
        end
        model_gen   = (model_gen + 1) % (1 << GW);
        e.is_commit = 1'b1;
        e.at        = t0 + n;
        e.pc        = 0;
        e.ins       = '0;
        e.gen       = model_gen;
        exp_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (rst && (execution_enable || state_commit)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {62'd0, execution_enable, state_commit}, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_kind", 64'(state_commit), 64'(mon_e.is_commit));
                check("event_cycle", 64'(cyc), 64'(mon_e.at));
                if (mon_e.is_commit) begin
                    check("commit_generation", 64'(generation), 64'(mon_e.gen));
                    check("commit_enable_low", 64'(execution_enable), 64'd0);
                end else begin
                    check("pc", 64'(program_counter), 64'(mon_e.pc));
                    check("instruction", 64'(instruction), 64'(mon_e.ins));
                end
            end
        end
    end

`ifndef SEQ_FRAME_SYNC_EN
    // Without the feature frame_sync must have no effect; keep it toggling.
    initial forever begin
        @(posedge clk);
        #1;
        frame_sync = 1'($urandom);
    end
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int bound;
        int b;
        bound = exp_q.size() * 2 + 50;
        b = 0;
        while (exp_q.size() != 0 && b < bound) begin
            tick();
            b++;
        end
        check({name, "_timeout"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (3) tick();
        check({name, "_idle_busy"}, 64'(busy), 64'd0);
        check({name, "_idle_addr"}, 64'(imem_addr), 64'd0);
    endtask

    task automatic single(input int n);
        int k;
        tick();
        k = cyc;
        prog_len = PCW'(n);
        run = 1'b1;
        if (n == 0) push_gen(k + 1, 0);
        else        push_gen(k + 3, n);
        tick();
        run = 1'b0;
        prog_len = PCW'($urandom);
        drain("single");
    endtask

`ifndef SEQ_FRAME_SYNC_EN
    task automatic b2b(input int g_cnt, input int fixed);
        int len[8];
        int ts[8];
        int k;
        int drop;
        for (int g = 0; g < g_cnt; g++) len[g] = (fixed != 0) ? fixed : int'($urandom_range(1, 5));
        tick();
        k = cyc;
        prog_len = PCW'(len[0]);
        run = 1'b1;
        ts[0] = k + 3;
        for (int g = 0; g < g_cnt; g++) begin
            push_gen(ts[g], len[g]);
            if (g + 1 < g_cnt) ts[g+1] = ts[g] + len[g] + 2;
        end
        drop = ts[g_cnt-1] + ((len[g_cnt-1] > 1) ? 1 : 0);
        while (cyc < drop) begin
            tick();
            if (cyc == k + 1) prog_len = PCW'($urandom);
            for (int g = 0; g + 1 < g_cnt; g++) if (cyc == ts[g]) prog_len = PCW'(len[g+1]);
            if (cyc == drop) begin
                run = 1'b0;
                prog_len = PCW'($urandom);
            end
        end
        drain("b2b");
    endtask
`else
    task automatic sync_gen(input int n, input int n2);
        int k;
        int t;
        tick();
        k = cyc;
        prog_len = PCW'(n);
        run = 1'b1;
        push_gen(k + 3, n);
        t = k + 3 + n + 1 + int'($urandom_range(1, 4));
        tick();
        prog_len = PCW'(n2);
        while (cyc < t) tick();
        frame_sync = 1'b1;
        push_gen(t + 2, n2);
        tick();
        frame_sync = 1'b0;
        run = 1'b0;
        drain("sync");
    endtask
`endif

    task automatic reset_mid_gen();
        int k;
        tick();
        k = cyc;
        prog_len = PCW'(4);
        run = 1'b1;
        push_gen(k + 3, 4);
        tick();
        run = 1'b0;
        while (cyc < k + 5) tick();
        #1;
        rst = 1'b0;
        #1;
        check("rst_enable", 64'(execution_enable), 64'd0);
        check("rst_commit", 64'(state_commit), 64'd0);
        check("rst_pc", 64'(program_counter), 64'd0);
        check("rst_instr", 64'(instruction), 64'd0);
        check("rst_generation", 64'(generation), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        exp_q.delete();
        model_gen = 0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (8) tick();
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_generation", 64'(generation), 64'd0);
        check("post_rst_addr", 64'(imem_addr), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << PCW); i++) mem[i] = IW'($urandom);
        mem[0] = 16'hA000;
        mem[1] = 16'hB001;
        mem[2] = 16'hC002;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_enable", 64'(execution_enable), 64'd0);
        check("reset_commit", 64'(state_commit), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_generation", 64'(generation), 64'd0);
        check("reset_addr", 64'(imem_addr), 64'd0);
        check("reset_pc", 64'(program_counter), 64'd0);
        check("reset_instr", 64'(instruction), 64'd0);
        tick();
        rst = 1'b1;
        repeat (2) tick();

        single(3);
        single(0);
        for (int i = 0; i < 6; i++) single(int'($urandom_range(0, 6)));
`ifndef SEQ_FRAME_SYNC_EN
        b2b(3, 2);
        b2b(1, 4);
        for (int i = 0; i < 5; i++) b2b(int'($urandom_range(2, 4)), 0);
`else
        sync_gen(3, 2);
        for (int i = 0; i < 4; i++) sync_gen(int'($urandom_range(1, 5)), int'($urandom_range(1, 5)));
`endif
        single((1 << PCW) - 1);
        reset_mid_gen();
        single(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
